// File: rtl/bcd_conv_scheduler.sv
// Two-requester binary-to-BCD converter sharing one serial double-dabble engine.
// Optional clamping of inputs above 999 is enabled by defining BCD_SATURATE_EN.
module bcd_conv_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [9:0] numBin0,
  output logic       ack0,
  input  logic       req1,
  input  logic [9:0] numBin1,
  output logic       ack1,
  output logic [3:0] centenas0,
  output logic [3:0] decenas0,
  output logic [3:0] unidades0,
  output logic [3:0] centenas1,
  output logic [3:0] decenas1,
  output logic [3:0] unidades1,
  output logic       busy,
  output logic       ovf0,
  output logic       ovf1
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] res0_q, res0_d, res1_q, res1_d;
  logic        id_q, id_d, last_q, last_d;
  logic        busy_q, busy_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic        gnt_s;
  logic [9:0]  gbin_s;
`ifdef BCD_SATURATE_EN
  logic        sat_q, sat_d, ovf0_q, ovf0_d, ovf1_q, ovf1_d;
`endif

  function automatic logic [3:0] add3(input logic [3:0] d);
    add3 = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Round-robin: on a tie the requester not served last wins.
  assign gnt_s  = (req0 & req1) ? ~last_q : req1;
  assign gbin_s = gnt_s ? numBin1 : numBin0;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bin_q   <= 10'd0;
      acc_q   <= 12'd0;
      res0_q  <= 12'd0;
      res1_q  <= 12'd0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef BCD_SATURATE_EN
      sat_q   <= 1'b0;
      ovf0_q  <= 1'b0;
      ovf1_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      id_q    <= id_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
`ifdef BCD_SATURATE_EN
      sat_q   <= sat_d;
      ovf0_q  <= ovf0_d;
      ovf1_q  <= ovf1_d;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    id_d    = id_q;
    last_d  = last_q;
    busy_d  = busy_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef BCD_SATURATE_EN
    sat_d   = sat_q;
    ovf0_d  = ovf0_q;
    ovf1_d  = ovf1_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req0 || req1) begin
          state_d = SHIFT;
          id_d    = gnt_s;
          last_d  = gnt_s;
          acc_d   = 12'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
`ifdef BCD_SATURATE_EN
          sat_d   = (gbin_s > 10'd999);
          bin_d   = (gbin_s > 10'd999) ? 10'd999 : gbin_s;
`else
          bin_d   = gbin_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Hundreds digit has nothing above it to carry into, so it is never
        // adjusted; unclamped 1000-1023 therefore read back as centenas 10.
        acc_d = 12'({acc_q[11:8], add3(acc_q[7:4]), add3(acc_q[3:0]), bin_q[9]});
        bin_d = {bin_q[8:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (id_q) begin
          res1_d = acc_q;
          ack1_d = 1'b1;
`ifdef BCD_SATURATE_EN
          ovf1_d = sat_q;
`endif
        end else begin
          res0_d = acc_q;
          ack0_d = 1'b1;
`ifdef BCD_SATURATE_EN
          ovf0_d = sat_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign centenas0 = res0_q[11:8];
  assign decenas0  = res0_q[7:4];
  assign unidades0 = res0_q[3:0];
  assign centenas1 = res1_q[11:8];
  assign decenas1  = res1_q[7:4];
  assign unidades1 = res1_q[3:0];
`ifdef BCD_SATURATE_EN
  assign ovf0      = ovf0_q;
  assign ovf1      = ovf1_q;
`else
  assign ovf0      = 1'b0;
  assign ovf1      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed self-checking bench for bcd_conv_scheduler.
module tb_bcd_conv_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, req0, req1, ack0, ack1, busy, ovf0, ovf1;
  logic [9:0] numBin0, numBin1;
  logic [3:0] centenas0, decenas0, unidades0, centenas1, decenas1, unidades1;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int cyc, bcnt, seen;

  bcd_conv_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .numBin0(numBin0), .ack0(ack0),
    .req1(req1), .numBin1(numBin1), .ack1(ack1),
    .centenas0(centenas0), .decenas0(decenas0), .unidades0(unidades0),
    .centenas1(centenas1), .decenas1(decenas1), .unidades1(unidades1),
    .busy(busy), .ovf0(ovf0), .ovf1(ovf1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until an ack is seen (0 if the bound expires).
  task automatic wait_ack(output int c, output int b);
    c = 0;
    b = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) b++;
      if (ack0 || ack1) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [11:0] r0();
    return {centenas0, decenas0, unidades0};
  endfunction
  function automatic logic [11:0] r1();
    return {centenas1, decenas1, unidades1};
  endfunction

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; numBin0 = 10'd0; numBin1 = 10'd0;
    @(negedge clk);
    check("rst_res0", {20'd0, r0()}, 32'h000);
    check("rst_res1", {20'd0, r1()}, 32'h000);
    check("rst_flags", {27'd0, ack0, ack1, busy, ovf0, ovf1}, 32'd0);
    do_reset();

    // Single conversion of 345
    numBin0 = 10'd345; req0 = 1'b1;
    wait_ack(cyc, bcnt);
    req0 = 1'b0;
    check("lat_345", cyc, 32'd12);
    check("busy_345", bcnt, 32'd11);
    check("ack0_345", {31'd0, ack0}, 32'd1);
    check("res_345", {20'd0, r0()}, 32'h345);
    @(negedge clk);
    check("ack_pulse", {30'd0, ack0, ack1}, 32'd0);

    // Simultaneous requests after reset: requester 0 wins the tie
    do_reset();
    numBin0 = 10'd7; numBin1 = 10'd999; req0 = 1'b1; req1 = 1'b1;
    wait_ack(cyc, bcnt);
    req0 = 1'b0;
    check("tie_first", {30'd0, ack0, ack1}, 32'b10);
    check("tie_res0", {20'd0, r0()}, 32'h007);
    wait_ack(cyc, bcnt);
    req1 = 1'b0;
    check("tie_gap", cyc, 32'd12);
    check("tie_second", {30'd0, ack0, ack1}, 32'b01);
    check("tie_res1", {20'd0, r1()}, 32'h999);
    check("tie_res0_hold", {20'd0, r0()}, 32'h007);

    // Both held: last served is 1, so order is 0,1,0
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(cyc, bcnt);
    check("rr_a", {30'd0, ack0, ack1}, 32'b10);
    wait_ack(cyc, bcnt);
    check("rr_b", {30'd0, ack0, ack1}, 32'b01);
    check("rr_b_gap", cyc, 32'd12);
    wait_ack(cyc, bcnt);
    req0 = 1'b0; req1 = 1'b0;
    check("rr_c", {30'd0, ack0, ack1}, 32'b10);
    check("rr_c_gap", cyc, 32'd12);

    // Out-of-range input
    numBin0 = 10'd1023; req0 = 1'b1;
    wait_ack(cyc, bcnt);
    req0 = 1'b0;
`ifdef BCD_SATURATE_EN
    check("res_1023", {20'd0, r0()}, 32'h999);
    check("ovf0_1023", {31'd0, ovf0}, 32'd1);
`else
    check("res_1023", {20'd0, r0()}, 32'hA23);
    check("ovf0_1023", {31'd0, ovf0}, 32'd0);
`endif
    check("ovf1_1023", {31'd0, ovf1}, 32'd0);
    numBin0 = 10'd345; req0 = 1'b1;
    wait_ack(cyc, bcnt);
    req0 = 1'b0;
    check("ovf0_clr", {31'd0, ovf0}, 32'd0);

    // Abort by reset mid-conversion of 512
    numBin0 = 10'd512; req0 = 1'b1;
    repeat (6) @(negedge clk);
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_res0", {20'd0, r0()}, 32'h000);
    check("abort_res1", {20'd0, r1()}, 32'h000);
    check("abort_flags", {27'd0, ack0, ack1, busy, ovf0, ovf1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) seen++;
    end
    check("abort_quiet", seen, 32'd0);
    numBin0 = 10'd512; req0 = 1'b1;
    wait_ack(cyc, bcnt);
    req0 = 1'b0;
    check("lat_512", cyc, 32'd12);
    check("res_512", {20'd0, r0()}, 32'h512);

    // numBin1 changes mid-conversion must not matter
    numBin1 = 10'd100; req1 = 1'b1;
    repeat (3) @(negedge clk);
    numBin1 = 10'd200;
    wait_ack(cyc, bcnt);
    req1 = 1'b0;
    check("ack1_100", {30'd0, ack0, ack1}, 32'b01);
    check("res_100", {20'd0, r1()}, 32'h100);
    check("res0_keep", {20'd0, r0()}, 32'h512);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
